regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core constants, writeback source indices and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 1 << REG_ADDR_W;
    localparam int NUM_SRC_DEFAULT = 3;

    typedef enum logic [1:0] {
        SRC_LSU = 2'd0,
        SRC_MDU = 2'd1,
        SRC_ALU = 2'd2
    } src_idx_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot grant with a pointer that moves past the
//               winner on every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] i_req,
    output logic [NUM_SRC-1:0] o_grant,
    output logic               o_grant_valid
);

    localparam int              IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDX_W-1:0] c_last = IDX_W'(NUM_SRC - 1);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_sel;
    logic               w_found;
    logic [NUM_SRC-1:0] w_grant;
    int                 w_pos;

    // Scan from the pointer upward; wrap by subtraction since pos < 2*NUM_SRC.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sel   = '0;
        w_grant = '0;
        w_pos   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= NUM_SRC) begin
                w_pos = w_pos - NUM_SRC;
            end
            w_sel = IDX_W'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                w_found        = 1'b1;
                w_idx          = w_sel;
                w_grant[w_sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_idx == c_last) ? '0 : w_idx + IDX_W'(1);
        end
    end

    assign o_grant       = w_grant;
    assign o_grant_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Writeback port arbitration into the register file plus the
//               pending-write scoreboard that drives the decode stall.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_rd,
    input  logic [NUM_SRC-1:0][XLEN-1:0]        src_data,
    input  logic                                iss_valid,
    input  logic [REG_ADDR_W-1:0]               iss_rd,
    input  logic [XLEN-1:0]                     instr,
    output logic                                stall,
    output logic                                wb_we,
    output logic [REG_ADDR_W-1:0]               wb_rd,
    output logic [XLEN-1:0]                     wb_data
);

    logic [NUM_SRC-1:0]    w_req;
    logic [NUM_SRC-1:0]    w_grant;
    logic                  w_grant_valid;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic [NUM_REGS-1:0]   w_pending;
    logic                  w_unused_instr;

    logic                  r_wb_we;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;
    logic [NUM_REGS-1:1]   r_pending;

    // Requests are masked in reset so nothing offered then is consumed.
    assign w_req = src_valid & {NUM_SRC{rst_n}};

    rr_arbiter #(
        .NUM_SRC       (NUM_SRC)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (w_req),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign src_ready = w_grant;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = w_sel_rd   | src_rd[i];
                w_sel_data = w_sel_data | src_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else if (w_grant_valid) begin
            r_wb_we   <= (w_sel_rd != '0);
            r_wb_rd   <= w_sel_rd;
            r_wb_data <= w_sel_data;
        end else begin
            r_wb_we   <= 1'b0;
        end
    end

    // Clear is applied before set so an issue wins over a same-edge writeback.
    assign w_set = (iss_valid && (iss_rd != '0)) ? reg_onehot(iss_rd) : '0;
    assign w_clr = r_wb_we ? reg_onehot(r_wb_rd) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr[NUM_REGS-1:1]) | w_set[NUM_REGS-1:1];
        end
    end

    assign w_pending = {r_pending, 1'b0};

    assign stall = w_pending[instr[19:15]] | w_pending[instr[24:20]] | w_pending[instr[11:7]];

    // Opcode and funct fields play no part in the hazard check.
    assign w_unused_instr = ^{instr[31:25], instr[14:12], instr[6:0]};

    assign wb_we   = r_wb_we;
    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;

endmodule
`default_nettype wire
